qpsk_sym_packetizer: RTL and testbench

Symbol-rate scheduler between the QPSK carrier/bit-sync recovery path and the AXI-stream output of the QPSK NoC block. Captures one recovered I/Q pair per bit-sync strobe, holds off output until the loops have settled, buffers symbols in a small FIFO and frames them into fixed-length AXI-stream packets with correct tlast. Enable changes and overflow are handled at packet boundaries, so the downstream packet stream never carries a truncated packet.

---
 rtl/qpsk_sym_packetizer.sv | 245 ++++++++++++++++++++++++
 tb/tb_qpsk_sym_packetizer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_sym_packetizer.sv
// qpsk_sym_packetizer
// Symbol-rate scheduler between the QPSK carrier/bit-sync recovery loops and
// the AXI-stream output. One I/Q pair is captured per bit-sync strobe once the
// loops have settled. Symbols are buffered in a small FIFO and framed into
// fixed-length packets with tlast. Enable changes and FIFO overflow are only
// acted on at packet boundaries, so no truncated packet ever leaves the block.
//
// Optional build macro:
//   QPSK_PKT_OVF_CNT_EN - when defined, ovf_count is a 16-bit saturating
//                         dropped-symbol counter. When undefined the counter
//                         is omitted and ovf_count reads 0. Drops happen
//                         either way.
module qpsk_sym_packetizer #(
    parameter int SPP_MAX = 256,
    parameter int FIFO_AW = 4,
    parameter int WARMUP  = 32
) (
    input  logic        ce_clk,
    input  logic        ce_rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] spp,
    input  logic [15:0] i_in,
    input  logic [15:0] q_in,
    input  logic        sym_stb,
    output logic [31:0] o_tdata,
    output logic        o_tvalid,
    output logic        o_tlast,
    input  logic        o_tready,
    output logic        locked,
    output logic [1:0]  state,
    output logic [15:0] ovf_count
);

    // Position counter must be able to hold SPP_MAX itself (latched length).
    localparam int PW    = $clog2(SPP_MAX + 1);
    // Warm-up counter only has to reach WARMUP-1.
    localparam int WW    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [PW-1:0]      SPP_MAX_V = PW'(SPP_MAX);
    localparam logic [PW-1:0]      POS_ONE   = PW'(1);
    localparam logic [WW-1:0]      WARM_LAST = WW'(WARMUP - 1);
    localparam logic [WW-1:0]      WARM_ONE  = WW'(1);
    localparam logic [FIFO_AW:0]   PTR_ONE   = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [WW-1:0]    warm_q, warm_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [PW-1:0]    spp_lat_q, spp_lat_d;
    logic             locked_q, locked_d;
    logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;

    // Symbol storage: {tlast, i, q}. Read asynchronously so a symbol pushed in
    // cycle N is visible at the output in cycle N+1.
    logic [32:0] mem [DEPTH];
    logic [32:0] head;

    logic          fifo_empty;
    logic          fifo_full;
    logic          capture_st;
    logic          push;
    logic          pop;
    logic          sym_last;
    logic [PW-1:0] spp_clamped;
    logic [PW-1:0] spp_eff;

    // ------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);

    assign capture_st = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    // Full is judged before any same-cycle pop, so a strobe against a full
    // FIFO is always dropped even if the reader frees a slot that cycle.
    assign push       = capture_st && sym_stb && !fifo_full;
    assign pop        = !fifo_empty && o_tready;

    assign head       = mem[rd_ptr_q[FIFO_AW-1:0]];
    assign o_tvalid   = !fifo_empty;
    assign o_tdata    = fifo_empty ? 32'd0 : head[31:0];
    assign o_tlast    = !fifo_empty && head[32];

    // ------------------------------------------------------------------
    // Packet length: 0 means 1, anything above SPP_MAX saturates.
    // At position 0 the live spp is used since it is about to be latched.
    // ------------------------------------------------------------------
    assign spp_clamped = (spp == 16'd0)           ? POS_ONE   :
                         (spp > 16'(SPP_MAX))     ? SPP_MAX_V :
                                                    spp[PW-1:0];
    assign spp_eff     = (pos_q == '0) ? spp_clamped : spp_lat_q;
    assign sym_last    = (pos_q == (spp_eff - POS_ONE));

    // Next-state decode for the run/warm-up controller.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_WARMUP;
                    warm_d  = '0;
                end
            end
            ST_WARMUP: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (sym_stb) begin
                    // The WARMUP-th strobe only moves us to RUN; it is not captured.
                    if (warm_q == WARM_LAST) begin
                        state_d = ST_RUN;
                        warm_d  = '0;
                    end else begin
                        warm_d = warm_q + WARM_ONE;
                    end
                end
            end
            ST_RUN: begin
                // Judge the boundary after this cycle's write so a symbol
                // captured alongside the disable still completes its packet.
                if (!enable) begin
                    state_d = (pos_d == '0) ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (push && sym_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        locked_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    end

    // Controller state register.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state_q  <= ST_IDLE;
            warm_q   <= '0;
            locked_q <= 1'b0;
        end else if (clear) begin
            state_q  <= ST_IDLE;
            warm_q   <= '0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            warm_q   <= warm_d;
            locked_q <= locked_d;
        end
    end

    // Next-state for packet position, latched length and FIFO pointers.
    // Dropped symbols leave the position untouched.
    always_comb begin
        pos_d     = pos_q;
        spp_lat_d = spp_lat_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push) begin
            if (pos_q == '0) begin
                spp_lat_d = spp_clamped;
            end
            pos_d    = sym_last ? '0 : (pos_q + POS_ONE);
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Datapath register: position, latched length, FIFO pointers.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            pos_q     <= '0;
            spp_lat_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else if (clear) begin
            pos_q     <= '0;
            spp_lat_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            pos_q     <= pos_d;
            spp_lat_q <= spp_lat_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Symbol storage write port; contents need no reset since the pointers
    // define what is valid.
    always_ff @(posedge ce_clk) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= {sym_last, i_in, q_in};
        end
    end

    assign state  = state_q;
    assign locked = locked_q;

`ifdef QPSK_PKT_OVF_CNT_EN
    logic        drop;
    logic [15:0] ovf_q, ovf_d;

    assign drop = capture_st && sym_stb && fifo_full;

    // Saturating dropped-symbol count.
    always_comb begin
        ovf_d = ovf_q;
        if (drop && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
    end

    // Overflow counter register; cleared only by reset or clear.
    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            ovf_q <= '0;
        end else if (clear) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf_count = ovf_q;
`else
    assign ovf_count = 16'd0;
`endif

endmodule

// File: tb/tb_qpsk_sym_packetizer.sv
// Testbench for qpsk_sym_packetizer: directed scenarios plus a randomized run,
// all checked against a queue-based behavioural model of the packetizer.
module tb_qpsk_sym_packetizer;

    localparam int SPP_MAX = 8;
    localparam int FIFO_AW = 2;
    localparam int WARMUP  = 4;
    localparam int DEPTH   = 1 << FIFO_AW;
`ifdef QPSK_PKT_OVF_CNT_EN
    localparam int OVF_ON = 1;
`else
    localparam int OVF_ON = 0;
`endif

    logic        ce_clk = 1'b0;
    logic        ce_rst = 1'b1;
    logic        clear = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] spp = 16'd0;
    logic [15:0] i_in = 16'd0;
    logic [15:0] q_in = 16'd0;
    logic        sym_stb = 1'b0;
    logic        o_tready = 1'b0;
    logic [31:0] o_tdata;
    logic        o_tvalid;
    logic        o_tlast;
    logic        locked;
    logic [1:0]  state;
    logic [15:0] ovf_count;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0..3, symbol queue, drop tally.
    int          m_state;
    int          m_warm;
    int          m_pos;
    int          m_spp;
    int          m_drops;
    logic [32:0] m_fifo[$];
    logic [32:0] exp_beats[$];
    logic [32:0] got_beats[$];

    qpsk_sym_packetizer #(
        .SPP_MAX(SPP_MAX),
        .FIFO_AW(FIFO_AW),
        .WARMUP (WARMUP)
    ) dut (
        .ce_clk   (ce_clk),
        .ce_rst   (ce_rst),
        .clear    (clear),
        .enable   (enable),
        .spp      (spp),
        .i_in     (i_in),
        .q_in     (q_in),
        .sym_stb  (sym_stb),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tlast  (o_tlast),
        .o_tready (o_tready),
        .locked   (locked),
        .state    (state),
        .ovf_count(ovf_count)
    );

    always #5 ce_clk = ~ce_clk;

    task automatic model_reset();
        m_state = 0;
        m_warm  = 0;
        m_pos   = 0;
        m_spp   = 1;
        m_drops = 0;
        m_fifo.delete();
    endtask

    function automatic logic [15:0] exp_ovf();
        if (OVF_ON == 0) return 16'h0;
        return (m_drops > 65535) ? 16'hFFFF : 16'(m_drops);
    endfunction

    // One clock of the specification's rules, using the inputs presented now.
    task automatic model_step();
        bit full;
        bit wrote_last;
        int nst;
        if (clear) begin
            model_reset();
            return;
        end
        full       = (m_fifo.size() == DEPTH);
        wrote_last = 1'b0;
        nst        = m_state;
        if ((m_fifo.size() != 0) && o_tready) exp_beats.push_back(m_fifo.pop_front());
        case (m_state)
            0: if (enable) begin nst = 1; m_warm = 0; end
            1: begin
                if (!enable) nst = 0;
                else if (sym_stb) begin
                    m_warm++;
                    if (m_warm == WARMUP) nst = 2;
                end
            end
            default: begin
                if (sym_stb) begin
                    if (full) m_drops++;
                    else begin
                        if (m_pos == 0) m_spp = (spp == 0) ? 1 : (int'(spp) > SPP_MAX) ? SPP_MAX : int'(spp);
                        wrote_last = (m_pos == m_spp - 1);
                        m_fifo.push_back({wrote_last, i_in, q_in});
                        m_pos = wrote_last ? 0 : m_pos + 1;
                    end
                end
                if (m_state == 2) begin
                    if (!enable) nst = (m_pos == 0) ? 0 : 3;
                end else begin
                    if (enable) nst = 2;
                    else if (wrote_last) nst = 0;
                end
            end
        endcase
        m_state = nst;
    endtask

    // Advance one clock: log the handshake, step the model, sample 1ns after the edge.
    task automatic tick();
        if (o_tvalid && o_tready) begin
            got_beats.push_back({o_tlast, o_tdata});
            $display("beat i=%h q=%h last=%0b", o_tdata[31:16], o_tdata[15:0], o_tlast);
        end
        model_step();
        @(posedge ce_clk);
        #1;
    endtask

    task automatic idle(input int n);
        sym_stb = 1'b0;
        for (int c = 0; c < n; c++) tick();
    endtask

    task automatic strobe(input logic [15:0] iv, input logic [15:0] qv);
        i_in    = iv;
        q_in    = qv;
        sym_stb = 1'b1;
        tick();
        sym_stb = 1'b0;
    endtask

    task automatic clear_logs();
        got_beats.delete();
        exp_beats.delete();
    endtask

    task automatic test_reset();
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d want=0", state); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got=%b want=0", o_tvalid); end
        checks++; if (o_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got=%b want=0", o_tlast); end
        checks++; if (o_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata got=%h want=0", o_tdata); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b want=0", locked); end
        checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL reset_ovf got=%0d want=0", ovf_count); end
        ce_rst = 1'b0;
        model_reset();
        idle(2);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_state got=%0d want=0", state); end
    endtask

    task automatic test_warmup();
        clear_logs();
        spp = 16'd3; o_tready = 1'b1; enable = 1'b1;
        idle(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL warm_enter got=%0d want=1", state); end
        for (int k = 1; k <= 10; k++) begin
            if (k == 5) begin
                checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL warm_pre_valid got=%b want=0", o_tvalid); end
            end
            strobe(16'(k), 16'(-k));
            if (k == 3) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL warm_lock3 got=%b want=0", locked); end
            end
            if (k == 4) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL warm_lock4 got=%b want=1", locked); end
                checks++; if (state !== 2'd2) begin errors++; $display("FAIL warm_run got=%0d want=2", state); end
            end
            if (k == 5) begin
                checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL warm_latency got=%b want=1", o_tvalid); end
                checks++; if (o_tdata !== {16'd5, 16'hFFFB}) begin errors++; $display("FAIL warm_first got=%h want=0005fffb", o_tdata); end
            end
            idle(1);
        end
        idle(3);
        checks++; if (got_beats.size() != 6) begin errors++; $display("FAIL warm_count got=%0d want=6", got_beats.size()); end
        for (int j = 0; j < got_beats.size() && j < 6; j++) begin
            int k = j + 5;
            logic [32:0] want;
            want = {(k == 7 || k == 10), 16'(k), 16'(-k)};
            checks++; if (got_beats[j] !== want) begin errors++; $display("FAIL warm_beat%0d got=%h want=%h", j, got_beats[j], want); end
        end
        checks++; if (got_beats.size() != exp_beats.size()) begin errors++; $display("FAIL warm_model_count got=%0d want=%0d", got_beats.size(), exp_beats.size()); end
        for (int j = 0; j < got_beats.size() && j < exp_beats.size(); j++) begin
            checks++; if (got_beats[j] !== exp_beats[j]) begin errors++; $display("FAIL warm_model%0d got=%h want=%h", j, got_beats[j], exp_beats[j]); end
        end
    endtask

    task automatic test_drain();
        clear_logs();
        spp = 16'd4;
        strobe(16'd1, 16'd11); idle(1);
        strobe(16'd2, 16'd12); idle(1);
        enable = 1'b0;
        idle(1);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL drain_enter got=%0d want=3", state); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL drain_locked got=%b want=1", locked); end
        strobe(16'd3, 16'd13);
        checks++; if (state !== 2'd3) begin errors++; $display("FAIL drain_hold got=%0d want=3", state); end
        idle(1);
        strobe(16'd4, 16'd14);
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL drain_exit got=%0d want=0", state); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL drain_unlock got=%b want=0", locked); end
        for (int k = 0; k < 3; k++) begin strobe(16'(20 + k), 16'd0); idle(1); end
        idle(3);
        checks++; if (got_beats.size() != 4) begin errors++; $display("FAIL drain_count got=%0d want=4", got_beats.size()); end
        for (int j = 0; j < got_beats.size() && j < 4; j++) begin
            logic [32:0] want;
            want = {(j == 3), 16'(j + 1), 16'(j + 11)};
            checks++; if (got_beats[j] !== want) begin errors++; $display("FAIL drain_beat%0d got=%h want=%h", j, got_beats[j], want); end
        end
        for (int j = 0; j < got_beats.size() && j < exp_beats.size(); j++) begin
            checks++; if (got_beats[j] !== exp_beats[j]) begin errors++; $display("FAIL drain_model%0d got=%h want=%h", j, got_beats[j], exp_beats[j]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] want_ovf;
        bit want_last[4];
        clear_logs();
        spp = 16'd3; o_tready = 1'b1; enable = 1'b1;
        idle(1);
        for (int k = 0; k < WARMUP; k++) begin strobe(16'd0, 16'd0); idle(1); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL ovf_run got=%0d want=2", state); end
        o_tready = 1'b0;
        for (int k = 1; k <= 6; k++) strobe(16'(100 + k), 16'(k));
        want_ovf = (OVF_ON != 0) ? 16'd2 : 16'd0;
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b want=1", o_tvalid); end
        checks++; if (ovf_count !== want_ovf) begin errors++; $display("FAIL ovf_count got=%0d want=%0d", ovf_count, want_ovf); end
        checks++; if (ovf_count !== exp_ovf()) begin errors++; $display("FAIL ovf_model got=%0d want=%0d", ovf_count, exp_ovf()); end
        o_tready = 1'b1;
        idle(6);
        want_last = '{0, 0, 1, 0};
        checks++; if (got_beats.size() != 4) begin errors++; $display("FAIL ovf_beats got=%0d want=4", got_beats.size()); end
        for (int j = 0; j < got_beats.size() && j < 4; j++) begin
            logic [32:0] want;
            want = {want_last[j], 16'(101 + j), 16'(j + 1)};
            checks++; if (got_beats[j] !== want) begin errors++; $display("FAIL ovf_beat%0d got=%h want=%h", j, got_beats[j], want); end
        end
        // Full FIFO with a pop and a strobe in the same cycle.
        clear_logs();
        o_tready = 1'b0;
        for (int k = 1; k <= 4; k++) strobe(16'(200 + k), 16'(k));
        o_tready = 1'b1;
        strobe(16'd205, 16'd5);
        o_tready = 1'b0;
        idle(1);
        want_ovf = (OVF_ON != 0) ? 16'd3 : 16'd0;
        checks++; if (ovf_count !== want_ovf) begin errors++; $display("FAIL fullpop_ovf got=%0d want=%0d", ovf_count, want_ovf); end
        o_tready = 1'b1;
        idle(6);
        checks++; if (got_beats.size() != 4) begin errors++; $display("FAIL fullpop_beats got=%0d want=4", got_beats.size()); end
        if (got_beats.size() == 4) begin
            checks++; if (got_beats[3][31:16] !== 16'd204) begin errors++; $display("FAIL fullpop_lastdata got=%0d want=204", got_beats[3][31:16]); end
        end
        for (int j = 0; j < got_beats.size() && j < exp_beats.size(); j++) begin
            checks++; if (got_beats[j] !== exp_beats[j]) begin errors++; $display("FAIL fullpop_model%0d got=%h want=%h", j, got_beats[j], exp_beats[j]); end
        end
    endtask

    task automatic test_spp_edges();
        bit want_last[$];
        clear_logs();
        o_tready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_state got=%0d want=0", state); end
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL clear_valid got=%b want=0", o_tvalid); end
        checks++; if (ovf_count !== 16'd0) begin errors++; $display("FAIL clear_ovf got=%0d want=0", ovf_count); end
        o_tready = 1'b1; enable = 1'b1;
        idle(1);
        for (int k = 0; k < WARMUP; k++) begin strobe(16'd0, 16'd0); idle(1); end
        spp = 16'd0;
        for (int k = 0; k < 5; k++) begin strobe(16'(k), 16'd1); idle(1); want_last.push_back(1); end
        spp = 16'd4;
        strobe(16'd10, 16'd2); idle(1);
        spp = 16'd2;
        for (int k = 0; k < 5; k++) begin strobe(16'(11 + k), 16'd2); idle(1); end
        want_last.push_back(0); want_last.push_back(0); want_last.push_back(0);
        want_last.push_back(1); want_last.push_back(0); want_last.push_back(1);
        spp = 16'd100;
        for (int k = 0; k < 8; k++) begin strobe(16'(30 + k), 16'd3); idle(1); want_last.push_back(k == 7); end
        idle(3);
        checks++; if (got_beats.size() != want_last.size()) begin errors++; $display("FAIL spp_count got=%0d want=%0d", got_beats.size(), want_last.size()); end
        for (int j = 0; j < got_beats.size() && j < want_last.size(); j++) begin
            checks++; if (got_beats[j][32] !== want_last[j]) begin errors++; $display("FAIL spp_last%0d got=%b want=%b", j, got_beats[j][32], want_last[j]); end
        end
        for (int j = 0; j < got_beats.size() && j < exp_beats.size(); j++) begin
            checks++; if (got_beats[j] !== exp_beats[j]) begin errors++; $display("FAIL spp_model%0d got=%h want=%h", j, got_beats[j], exp_beats[j]); end
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        o_tready = 1'b0;
        strobe(16'd50, 16'd1);
        strobe(16'd51, 16'd2);
        checks++; if (o_tvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b want=1", o_tvalid); end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rst_pre_state got=%0d want=2", state); end
        #2;
        ce_rst = 1'b1;
        enable = 1'b0;
        #1;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b want=0", o_tvalid); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_async_state got=%0d want=0", state); end
        model_reset();
        @(posedge ce_clk);
        #1;
        ce_rst = 1'b0;
        checks++; if (o_tvalid !== 1'b0) begin errors++; $display("FAIL rst_empty got=%b want=0", o_tvalid); end
        o_tready = 1'b1; enable = 1'b1;
        idle(1);
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_warm got=%0d want=1", state); end
        for (int k = 0; k < WARMUP - 1; k++) begin strobe(16'd0, 16'd0); idle(1); end
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL rst_warm_hold got=%0d want=1", state); end
        strobe(16'd0, 16'd0);
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL rst_rerun got=%0d want=2", state); end
        idle(2);
    endtask

    task automatic test_random();
        clear_logs();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 4) enable = ~enable;
            sym_stb  = ($urandom_range(0, 99) < 60);
            o_tready = ($urandom_range(0, 99) < 65);
            spp      = 16'($urandom_range(0, 12));
            i_in     = 16'($urandom);
            q_in     = 16'($urandom);
            tick();
            checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state c=%0d got=%0d want=%0d", c, state, m_state); end
            checks++; if (locked !== (m_state >= 2)) begin errors++; $display("FAIL rnd_locked c=%0d got=%b", c, locked); end
            checks++; if (o_tvalid !== (m_fifo.size() != 0)) begin errors++; $display("FAIL rnd_valid c=%0d got=%b want=%0d", c, o_tvalid, m_fifo.size() != 0); end
            if (m_fifo.size() != 0) begin
                checks++; if ({o_tlast, o_tdata} !== m_fifo[0]) begin errors++; $display("FAIL rnd_head c=%0d got=%h want=%h", c, {o_tlast, o_tdata}, m_fifo[0]); end
            end
            checks++; if (ovf_count !== exp_ovf()) begin errors++; $display("FAIL rnd_ovf c=%0d got=%0d want=%0d", c, ovf_count, exp_ovf()); end
        end
        sym_stb = 1'b0; enable = 1'b0; o_tready = 1'b1;
        idle(10);
        checks++; if (got_beats.size() != exp_beats.size()) begin errors++; $display("FAIL rnd_count got=%0d want=%0d", got_beats.size(), exp_beats.size()); end
        for (int j = 0; j < got_beats.size() && j < exp_beats.size(); j++) begin
            checks++; if (got_beats[j] !== exp_beats[j]) begin errors++; $display("FAIL rnd_beat%0d got=%h want=%h", j, got_beats[j], exp_beats[j]); end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge ce_clk);
        #1;
        test_reset();
        test_warmup();
        test_drain();
        test_overflow();
        test_spp_edges();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
